// File: rtl/tdm_demux_1_16.sv
// Time-division demultiplexer, 1 serial stream to NUM_CHANNELS parallel channels.
// Samples are collected into shadow registers behind a frame sync. The parallel
// output is refreshed only when a frame completes, so a partial frame is never
// visible. An early sync aborts the partial frame and restarts collection.
module tdm_demux_1_16 #(
  parameter int NUM_CHANNELS = 16,
  parameter int DATA_WIDTH   = 1,
  parameter int SEL_WIDTH    = $clog2(NUM_CHANNELS)
) (
  input  logic                               Clock_In,
  input  logic                               Reset_In,
  input  logic                               Enable_In,
  input  logic                               Valid_In,
  input  logic                               Frame_Sync_In,
  input  logic [DATA_WIDTH-1:0]              Data_In,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] Channel_Data_Out,
  output logic                               Frame_Valid_Out,
  output logic                               Frame_Error_Out,
  output logic [SEL_WIDTH-1:0]               Expected_Select_Out
);

  localparam logic [SEL_WIDTH-1:0] LAST_CH = SEL_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [SEL_WIDTH-1:0] ONE_CH  = SEL_WIDTH'(1);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t                state;
  logic [SEL_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] shadow [NUM_CHANNELS];
  logic                  accept;

  // A sample is taken only when both the link and the block are enabled.
  assign accept = Enable_In & Valid_In;

  // Counter is a register; in HUNT it is held at 0.
  assign Expected_Select_Out = cnt;

  // Frame FSM: steers samples into shadow registers and publishes complete frames.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state            <= HUNT;
      cnt              <= '0;
      Channel_Data_Out <= '0;
      Frame_Valid_Out  <= 1'b0;
      Frame_Error_Out  <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      Frame_Valid_Out <= 1'b0;
      Frame_Error_Out <= 1'b0;
      if (accept) begin
        case (state)
          HUNT: begin
            // Non-sync samples are dropped until channel 0 is seen.
            if (Frame_Sync_In) begin
              shadow[0] <= Data_In;
              cnt       <= ONE_CH;
              state     <= COLLECT;
            end
          end
          COLLECT: begin
            if (Frame_Sync_In) begin
              // Early sync: abandon the partial frame and restart at channel 0.
              Frame_Error_Out <= 1'b1;
              shadow[0]       <= Data_In;
              cnt             <= ONE_CH;
            end else begin
              shadow[cnt] <= Data_In;
              if (cnt == LAST_CH) begin
                // Last channel bypasses the shadow so the frame publishes next cycle.
                for (int k = 0; k < NUM_CHANNELS - 1; k++) begin
                  Channel_Data_Out[k*DATA_WIDTH +: DATA_WIDTH] <= shadow[k];
                end
                Channel_Data_Out[(NUM_CHANNELS-1)*DATA_WIDTH +: DATA_WIDTH] <= Data_In;
                Frame_Valid_Out <= 1'b1;
                cnt             <= '0;
                state           <= HUNT;
              end else begin
                cnt <= cnt + ONE_CH;
              end
            end
          end
          default: begin
            state <= HUNT;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1_16.sv
// Scoreboard bench for tdm_demux_1_16: stimulus queues expected frame/error
// pulses, a negedge monitor pops and compares them whenever a pulse appears.
module tb_tdm_demux_1_16;

  logic        Clock_In;
  logic        Reset_In;
  logic        Enable_In;
  logic        Valid_In;
  logic        Frame_Sync_In;
  logic [0:0]  Data_In;
  logic [15:0] Channel_Data_Out;
  logic        Frame_Valid_Out;
  logic        Frame_Error_Out;
  logic [3:0]  Expected_Select_Out;

  typedef struct {
    bit          err;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e_m;
  int          cyc;
  int          n_pass;
  int          n_total;
  logic [15:0] model_cdo;

  tdm_demux_1_16 dut (
    .Clock_In            (Clock_In),
    .Reset_In            (Reset_In),
    .Enable_In           (Enable_In),
    .Valid_In            (Valid_In),
    .Frame_Sync_In       (Frame_Sync_In),
    .Data_In             (Data_In),
    .Channel_Data_Out    (Channel_Data_Out),
    .Frame_Valid_Out     (Frame_Valid_Out),
    .Frame_Error_Out     (Frame_Error_Out),
    .Expected_Select_Out (Expected_Select_Out)
  );

  initial begin
    Clock_In = 1'b0;
    forever #5 Clock_In = ~Clock_In;
  end

  initial cyc = 0;
  always @(posedge Clock_In) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every pulse must match the head of the scoreboard; between pulses the output holds.
  always @(negedge Clock_In) begin
    if (Reset_In) begin
      model_cdo = 16'h0;
    end else if (Frame_Valid_Out || Frame_Error_Out) begin
      chk("pulse_exclusive", 32'(Frame_Valid_Out & Frame_Error_Out), 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, Frame_Valid_Out, Frame_Error_Out}, 32'd0);
      end else begin
        e_m = q.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e_m.cyc));
        chk("pulse_kind_err", 32'(Frame_Error_Out), 32'(e_m.err));
        if (!e_m.err) begin
          chk("frame_data", 32'(Channel_Data_Out), 32'(e_m.data));
          model_cdo = e_m.data;
        end else begin
          chk("cdo_hold_on_err", 32'(Channel_Data_Out), 32'(model_cdo));
        end
      end
    end else begin
      chk("cdo_hold", 32'(Channel_Data_Out), 32'(model_cdo));
    end
  end

  // One sample presented for exactly one clock edge, after an optional idle gap.
  task automatic send(input bit sync, input bit d);
    Valid_In      = 1'b1;
    Frame_Sync_In = sync;
    Data_In       = d;
    @(posedge Clock_In); #1;
    Valid_In      = 1'b0;
    Frame_Sync_In = 1'b0;
  endtask

  task automatic push_exp(input bit err, input logic [15:0] d);
    exp_t e;
    e.err  = err;
    e.data = d;
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  task automatic send_frame(input logic [15:0] p, input bit gapped);
    for (int k = 0; k < 16; k++) begin
      if (gapped) begin
        int g;
        g = int'($urandom_range(0, 3));
        repeat (g) begin
          @(posedge Clock_In); #1;
          chk("sel_hold_gap", 32'(Expected_Select_Out), 32'(k));
        end
        if (k == 8) begin
          Enable_In     = 1'b0;
          Valid_In      = 1'b1;
          Frame_Sync_In = 1'b0;
          Data_In       = ~p[k];
          repeat (5) begin
            @(posedge Clock_In); #1;
            chk("sel_hold_enable_low", 32'(Expected_Select_Out), 32'd8);
          end
          Enable_In = 1'b1;
          Valid_In  = 1'b0;
        end
      end
      send(k == 0, p[k]);
      if (k == 15) push_exp(1'b0, p);
      chk("sel_after_sample", 32'(Expected_Select_Out), 32'((k + 1) % 16));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] p;
    model_cdo     = 16'h0;
    n_pass        = 0;
    n_total       = 0;
    Reset_In      = 1'b0;
    Enable_In     = 1'b1;
    Valid_In      = 1'b0;
    Frame_Sync_In = 1'b0;
    Data_In       = 1'b0;

    // Reset asserted between clock edges: outputs clear without a clock.
    #2 Reset_In = 1'b1;
    #1;
    chk("reset_cdo", 32'(Channel_Data_Out), 32'd0);
    chk("reset_fv", 32'(Frame_Valid_Out), 32'd0);
    chk("reset_fe", 32'(Frame_Error_Out), 32'd0);
    chk("reset_sel", 32'(Expected_Select_Out), 32'd0);
    @(posedge Clock_In); #1;
    Reset_In = 1'b0;
    @(posedge Clock_In); #1;

    // Hunt drop: non-sync samples are ignored, then an all-zero frame.
    repeat (5) begin
      send(1'b0, 1'b1);
      chk("hunt_sel", 32'(Expected_Select_Out), 32'd0);
    end
    send_frame(16'h0000, 1'b0);

    // One-hot and walking patterns, back-to-back.
    send_frame(16'h0001, 1'b0);
    send_frame(16'hFFFE, 1'b0);
    for (int b = 0; b < 16; b++) begin
      p = 16'h0001 << b;
      send_frame(p, 1'b0);
    end

    // Gapped input with an enable-low stretch mid-frame.
    send_frame(16'h5A3C, 1'b1);
    @(posedge Clock_In); #1;
    send_frame(16'hFFFE, 1'b1);

    // Early sync: 8-sample partial frame discarded, second frame published.
    send(1'b1, 1'b1);
    repeat (7) send(1'b0, 1'b1);
    chk("sel_before_early_sync", 32'(Expected_Select_Out), 32'd8);
    p = 16'h1234;
    send(1'b1, p[0]);
    push_exp(1'b1, 16'h0);
    chk("sel_after_early_sync", 32'(Expected_Select_Out), 32'd1);
    for (int k = 1; k < 16; k++) send(1'b0, p[k]);
    push_exp(1'b0, p);
    @(posedge Clock_In); #1;

    // Reset mid-frame: asynchronous clear, then a clean frame.
    send(1'b1, 1'b1);
    repeat (9) send(1'b0, 1'b1);
    chk("sel_before_reset", 32'(Expected_Select_Out), 32'd10);
    #2 Reset_In = 1'b1;
    #1;
    chk("midreset_cdo", 32'(Channel_Data_Out), 32'd0);
    chk("midreset_sel", 32'(Expected_Select_Out), 32'd0);
    chk("midreset_fv", 32'(Frame_Valid_Out), 32'd0);
    @(posedge Clock_In); #1;
    Reset_In = 1'b0;
    @(posedge Clock_In); #1;
    send_frame(16'hA5A5, 1'b0);

    repeat (4) @(posedge Clock_In);
    #1;
    chk("queue_drain", 32'(q.size()), 32'd0);
    chk("final_cdo", 32'(Channel_Data_Out), 32'h0000A5A5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1_16.md
# tdm_demux_1_16

Time-division demultiplexer, the receive-side counterpart of the 16:1 MUX. It takes a serial sample stream in which channel 0 is flagged by a frame sync. Each sample is steered into a per-channel shadow register. When the frame is complete, all channels are presented in parallel with a one-cycle frame-valid strobe. It sits at the far end of a link driven by a MUX with a scanning select counter.

## Interface
- NUM_CHANNELS, 16, channels per frame; integer ≥ 2.
- DATA_WIDTH, 1, bits per channel sample.
- SEL_WIDTH, $clog2(NUM_CHANNELS), width of the channel index (derived; not overridden).

Ports:
- Clock_In  input  1  single clock; all logic on rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Enable_In  input  1  when low, samples are ignored and all state is held.
- Valid_In  input  1  Data_In carries a sample this cycle.
- Frame_Sync_In  input  1  qualified by Valid_In; marks the sample as channel 0.
- Data_In  input  DATA_WIDTH  sample data.
- Channel_Data_Out  output  NUM_CHANNELS*DATA_WIDTH  last complete frame; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- Frame_Valid_Out  output  1  one-cycle pulse when Channel_Data_Out updates.
- Frame_Error_Out  output  1  one-cycle pulse when a partial frame is aborted by an early sync.
- Expected_Select_Out  output  SEL_WIDTH  channel index the next accepted sample will be written to (0 in HUNT).

## Operation
- An accepted sample requires Enable_In=1 and Valid_In=1 on a rising edge.
- There are two states: HUNT and COLLECT. Reset enters HUNT.
- HUNT:
  - An accepted sample with Frame_Sync_In=1 writes shadow[0], sets the counter to 1, and moves to COLLECT.
  - An accepted sample with Frame_Sync_In=0 is dropped silently. The state stays HUNT and no error is raised.
- COLLECT, on an accepted sample with Frame_Sync_In=0:
  - The sample is written to shadow[counter].
  - If counter < NUM_CHANNELS-1, the counter increments.
  - If counter = NUM_CHANNELS-1, the frame completes:
    - Channel_Data_Out is loaded with shadow[0..N-2] plus the incoming sample as channel N-1.
    - Frame_Valid_Out pulses.
    - The counter clears to 0 and the state returns to HUNT.
- COLLECT, on an accepted sample with Frame_Sync_In=1 (early sync):
  - Frame_Error_Out pulses and the partial frame is discarded.
  - Channel_Data_Out is not updated.
  - The sample is written as shadow[0], the counter is set to 1, and the state remains COLLECT.
- Non-accepted cycles (Valid_In=0 or Enable_In=0) change nothing. Gaps of any length between samples are legal.
- Channel_Data_Out holds its value between frames. It changes only on frame completion.
- Shadow registers never reach the outputs directly. A partial frame is never visible.
- Expected_Select_Out equals the counter, which is always 0 in HUNT.

## Timing
- Reset values:
  - Channel_Data_Out = 0
  - Frame_Valid_Out = 0
  - Frame_Error_Out = 0
  - Expected_Select_Out = 0
  - shadow = 0
  - state = HUNT
- Reset is asynchronous. Asserting it mid-frame clears everything immediately with no strobe. The first accepted sync after deassertion starts a fresh frame.
- All outputs are registered.
- Latency:
  - Frame_Valid_Out and the new Channel_Data_Out appear in the cycle following the edge that accepted the last channel.
  - Frame_Error_Out appears in the cycle following the edge that accepted the early sync.
- Minimum frame time is NUM_CHANNELS consecutive accepted samples. Back-to-back frames are supported: the sync for frame n+1 may arrive on the cycle right after the last sample of frame n, giving one Frame_Valid_Out pulse per NUM_CHANNELS cycles.
- Frame_Valid_Out and Frame_Error_Out are never high in the same cycle.

## Test plan
- **Reset:** assert Reset_In mid-cycle with no clock activity → all outputs read 0 immediately; Expected_Select_Out = 0.
- **One-hot frames:** with defaults, send 16 consecutive samples with sync on the first and data = bit k of 0x0001, then of 0xFFFE, then walk the 1 through all 16 positions.
  - Each frame produces Channel_Data_Out equal to its pattern.
  - Exactly one Frame_Valid_Out pulse per frame, in the cycle after sample 15.
- **Gapped input:** same frame with random 0–3 cycle Valid_In gaps and Enable_In low for 5 cycles mid-frame → identical Channel_Data_Out. Expected_Select_Out holds through the gaps.
- **Early sync:** sync, then 7 samples, then sync again, then 15 samples → Frame_Error_Out pulses once after the second sync. The first Frame_Valid_Out comes only after the second frame completes, and Channel_Data_Out contains second-frame data only.
- **Hunt drop:** 5 non-sync samples (data 1) from reset, then a full frame of 0x0000 → no pulses during the drops. After the frame, Channel_Data_Out = 0 and Frame_Valid_Out pulses once.
- **Reset mid-frame:** sync, then 9 samples of 1, then a Reset_In pulse, then a full frame of 0xA5A5 → outputs 0 after reset, then Channel_Data_Out = 0xA5A5 with one Frame_Valid_Out pulse and no error.
